// File: rtl/pll_reset_sequencer.sv
// Lock-qualified reset sequencer: synchronises PLL LOCKED, holds reset for a fixed time after lock,
// then releases NUM_RST reset outputs one at a time; everything re-asserts on lock loss or soft reset.
//
// state      | meaning
// WAIT_LOCK  | all resets asserted, waiting for synchronised lock
// HOLD       | lock seen, counting down the hold time before the first release
// RELEASE    | releasing o_rst[0..NUM_RST-1] in order, STAGGER_CYCLES apart
// RUN        | all resets released, o_ready high until lock loss or soft reset

module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int NUM_RST        = 2,
    parameter int STAGGER_CYCLES = 4,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_locked,
    input  logic                  i_soft_rst,
    output logic [NUM_RST-1:0]    o_rst,
    output logic                  o_ready,
    output logic [LOSS_CNT_W-1:0] o_loss_cnt
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int STG_W  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LOAD  = STG_W'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t state;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    logic                  locked_s;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [STG_W-1:0]      stg_cnt;
    logic [NUM_RST-1:0]    rst_q;
    logic [NUM_RST-1:0]    rst_next;
    logic                  ready_q;
    logic [LOSS_CNT_W-1:0] loss_q;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Shifting left in ones-from-the-top order releases o_rst[0] first and
    // guarantees a higher index is never low while a lower one is still high.
    assign rst_next = rst_q << 1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_locked};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_WAIT_LOCK;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            loss_q   <= '0;
        end else begin
            unique case (state)
                ST_WAIT_LOCK: begin
                    rst_q   <= '1;
                    ready_q <= 1'b0;
                    if (locked_s) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end

                ST_HOLD: begin
                    rst_q   <= '1;
                    ready_q <= 1'b0;
                    if (!locked_s) begin
                        state <= ST_WAIT_LOCK;
                    end else if (i_soft_rst) begin
                        hold_cnt <= HOLD_LOAD;
                    end else if (hold_cnt == '0) begin
                        state   <= ST_RELEASE;
                        stg_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end

                ST_RELEASE, ST_RUN: begin
                    // Lock loss outranks a simultaneous soft reset so the event is counted.
                    if (!locked_s) begin
                        state   <= ST_WAIT_LOCK;
                        rst_q   <= '1;
                        ready_q <= 1'b0;
                        if (loss_q != '1) begin
                            loss_q <= loss_q + LOSS_CNT_W'(1);
                        end
                    end else if (i_soft_rst) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_LOAD;
                        rst_q    <= '1;
                        ready_q  <= 1'b0;
                    end else if (state == ST_RELEASE) begin
                        if (stg_cnt == '0) begin
                            rst_q <= rst_next;
                            if (rst_next == '0) begin
                                state   <= ST_RUN;
                                ready_q <= 1'b1;
                            end else begin
                                stg_cnt <= STG_LOAD;
                            end
                        end else begin
                            stg_cnt <= stg_cnt - STG_W'(1);
                        end
                    end
                end

                default: begin
                    state   <= ST_WAIT_LOCK;
                    rst_q   <= '1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_rst      = rst_q;
    assign o_ready    = ready_q;
    assign o_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: default instance plus a 2-bit loss counter instance
// and a 4-channel, 1-cycle-stagger instance, all sharing clock and reset.

module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       lk, sr, lk2, sr2, lk4, sr4;
    logic [1:0] r;
    logic       rdy;
    logic [7:0] loss;
    logic [1:0] r2;
    logic       rdy2;
    logic [1:0] loss2;
    logic [3:0] r4;
    logic       rdy4;
    logic [7:0] loss4;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_locked(lk), .i_soft_rst(sr),
        .o_rst(r), .o_ready(rdy), .o_loss_cnt(loss)
    );

    pll_reset_sequencer #(.LOSS_CNT_W(2)) dut_w2 (
        .i_clk(clk), .i_rst(rst), .i_locked(lk2), .i_soft_rst(sr2),
        .o_rst(r2), .o_ready(rdy2), .o_loss_cnt(loss2)
    );

    pll_reset_sequencer #(.NUM_RST(4), .STAGGER_CYCLES(1)) dut_n4 (
        .i_clk(clk), .i_rst(rst), .i_locked(lk4), .i_soft_rst(sr4),
        .o_rst(r4), .o_ready(rdy4), .o_loss_cnt(loss4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lk = 1'b0; sr = 1'b0; lk2 = 1'b0; sr2 = 1'b0; lk4 = 1'b0; sr4 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (r !== 2'b11) begin miscompares++; $display("FAIL reset_rst: got %b expected 11", r); end
        vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", rdy); end
        vectors++; if (loss !== 8'd0) begin miscompares++; $display("FAIL reset_loss: got %0d expected 0", loss); end
        vectors++; if (r4 !== 4'b1111) begin miscompares++; $display("FAIL reset_rst4: got %b expected 1111", r4); end
        vectors++; if (loss2 !== 2'd0) begin miscompares++; $display("FAIL reset_loss2: got %0d expected 0", loss2); end
        // soft reset while unlocked must not change anything
        sr = 1'b1;
        repeat (4) tick();
        sr = 1'b0;
        vectors++; if (r !== 2'b11 || rdy !== 1'b0) begin
            miscompares++; $display("FAIL wait_soft_ignored: got rst=%b rdy=%b expected rst=11 rdy=0", r, rdy);
        end
        do_reset();
    endtask

    // T1: lock from edge 0 -> o_rst[0] falls at edge 19, o_rst[1] and o_ready at edge 23
    task automatic test_lock_release();
        logic [1:0] exp_r;
        do_reset();
        lk = 1'b1;
        for (int e = 0; e <= 25; e++) begin
            tick();
            exp_r = (e < 19) ? 2'b11 : (e < 23) ? 2'b10 : 2'b00;
            vectors++; if (r !== exp_r) begin miscompares++; $display("FAIL t1_rst edge %0d: got %b expected %b", e, r, exp_r); end
            vectors++; if (rdy !== (e >= 23)) begin miscompares++; $display("FAIL t1_ready edge %0d: got %b expected %b", e, rdy, (e >= 23)); end
        end
    endtask

    // T3: lock drop in RUN is seen after the synchroniser; relock repeats T1 timing
    task automatic test_lock_loss();
        logic [1:0] exp_r;
        lk = 1'b0;
        tick();
        tick();
        vectors++; if (r !== 2'b00 || rdy !== 1'b1) begin
            miscompares++; $display("FAIL t3_still_run: got rst=%b rdy=%b expected rst=00 rdy=1", r, rdy);
        end
        tick();
        vectors++; if (r !== 2'b11) begin miscompares++; $display("FAIL t3_abort_rst: got %b expected 11", r); end
        vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL t3_abort_ready: got %b expected 0", rdy); end
        vectors++; if (loss !== 8'd1) begin miscompares++; $display("FAIL t3_loss: got %0d expected 1", loss); end
        lk = 1'b1;
        for (int e = 0; e <= 23; e++) begin
            tick();
            if (e == 18 || e == 19 || e == 22 || e == 23) begin
                exp_r = (e < 19) ? 2'b11 : (e < 23) ? 2'b10 : 2'b00;
                vectors++; if (r !== exp_r || rdy !== (e >= 23)) begin
                    miscompares++; $display("FAIL t3_relock edge %0d: got rst=%b rdy=%b expected rst=%b rdy=%b", e, r, rdy, exp_r, (e >= 23));
                end
            end
        end
    endtask

    // T4: soft reset in RUN reruns hold + stagger, loss count untouched
    task automatic test_soft_run();
        logic [1:0] exp_r;
        sr = 1'b1;
        tick();
        sr = 1'b0;
        vectors++; if (r !== 2'b11 || rdy !== 1'b0) begin
            miscompares++; $display("FAIL t4_abort: got rst=%b rdy=%b expected rst=11 rdy=0", r, rdy);
        end
        for (int k = 1; k <= 21; k++) begin
            tick();
            exp_r = (k < 17) ? 2'b11 : (k < 21) ? 2'b10 : 2'b00;
            vectors++; if (r !== exp_r || rdy !== (k >= 21)) begin
                miscompares++; $display("FAIL t4_rerun k=%0d: got rst=%b rdy=%b expected rst=%b rdy=%b", k, r, rdy, exp_r, (k >= 21));
            end
        end
        vectors++; if (loss !== 8'd1) begin miscompares++; $display("FAIL t4_loss: got %0d expected 1", loss); end
    endtask

    // synchronous reset mid-run clears everything including the loss count
    task automatic test_reset_override();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (r !== 2'b11 || rdy !== 1'b0) begin
            miscompares++; $display("FAIL override_rst: got rst=%b rdy=%b expected rst=11 rdy=0", r, rdy);
        end
        vectors++; if (loss !== 8'd0) begin miscompares++; $display("FAIL override_loss: got %0d expected 0", loss); end
    endtask

    // T2: one-cycle lock dip sampled at edge 10 restarts the hold; release moves to edge 30/34
    task automatic test_lock_glitch();
        logic [1:0] exp_r;
        do_reset();
        for (int e = 0; e <= 35; e++) begin
            lk = (e == 10) ? 1'b0 : 1'b1;
            tick();
            exp_r = (e < 30) ? 2'b11 : (e < 34) ? 2'b10 : 2'b00;
            vectors++; if (r !== exp_r || rdy !== (e >= 34)) begin
                miscompares++; $display("FAIL t2_glitch edge %0d: got rst=%b rdy=%b expected rst=%b rdy=%b", e, r, rdy, exp_r, (e >= 34));
            end
        end
        vectors++; if (loss !== 8'd0) begin miscompares++; $display("FAIL t2_loss: got %0d expected 0", loss); end
    endtask

    // soft reset sampled at edge 10 in HOLD reloads the hold counter: release at edge 27
    task automatic test_soft_hold();
        logic [1:0] exp_r;
        do_reset();
        lk = 1'b1;
        for (int e = 0; e <= 31; e++) begin
            sr = (e == 10);
            tick();
            exp_r = (e < 27) ? 2'b11 : (e < 31) ? 2'b10 : 2'b00;
            vectors++; if (r !== exp_r || rdy !== (e >= 31)) begin
                miscompares++; $display("FAIL soft_hold edge %0d: got rst=%b rdy=%b expected rst=%b rdy=%b", e, r, rdy, exp_r, (e >= 31));
            end
        end
        sr = 1'b0;
    endtask

    // T5: 2-bit loss counter saturates at 3
    task automatic test_loss_saturate();
        logic [1:0] exp_l;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            lk2 = 1'b1;
            repeat (24) tick();
            vectors++; if (rdy2 !== 1'b1) begin miscompares++; $display("FAIL t5_run event %0d: got rdy=%b expected 1", i, rdy2); end
            lk2 = 1'b0;
            repeat (3) tick();
            exp_l = (i < 3) ? 2'(i) : 2'd3;
            vectors++; if (loss2 !== exp_l || r2 !== 2'b11) begin
                miscompares++; $display("FAIL t5_loss event %0d: got loss=%0d rst=%b expected loss=%0d rst=11", i, loss2, r2, exp_l);
            end
        end
    endtask

    // T6: four channels release on consecutive edges; soft + lock loss together counts as loss
    task automatic test_four_channel();
        logic [3:0] full = 4'b1111;
        logic [3:0] exp_r;
        do_reset();
        lk4 = 1'b1;
        for (int e = 0; e <= 22; e++) begin
            tick();
            exp_r = (e < 19) ? full : (full << (e - 18));
            vectors++; if (r4 !== exp_r || rdy4 !== (e >= 22)) begin
                miscompares++; $display("FAIL t6_stagger edge %0d: got rst=%b rdy=%b expected rst=%b rdy=%b", e, r4, rdy4, exp_r, (e >= 22));
            end
        end
        lk4 = 1'b0;
        tick();
        tick();
        sr4 = 1'b1;
        tick();
        sr4 = 1'b0;
        vectors++; if (r4 !== 4'b1111 || rdy4 !== 1'b0) begin
            miscompares++; $display("FAIL t6_abort: got rst=%b rdy=%b expected rst=1111 rdy=0", r4, rdy4);
        end
        vectors++; if (loss4 !== 8'd1) begin miscompares++; $display("FAIL t6_loss: got %0d expected 1", loss4); end
        repeat (5) tick();
        vectors++; if (r4 !== 4'b1111 || loss4 !== 8'd1) begin
            miscompares++; $display("FAIL t6_settle: got rst=%b loss=%0d expected rst=1111 loss=1", r4, loss4);
        end
    endtask

    initial begin
        test_reset();
        test_lock_release();
        test_lock_loss();
        test_soft_run();
        test_reset_override();
        test_lock_glitch();
        test_soft_hold();
        test_loss_saturate();
        test_four_channel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
